xcc: RTL and testbench

//  Circular-buffer occupancy/pointer controller for a power-of-2 ring of LENGTH slots.

---
 rtl/xcc.sv | 87 ++++++++
 tb/tb_xcc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/xcc.sv
// ---------------------------------------------------------------------------
// xcc - circular-buffer occupancy / pointer controller
//
// Tracks read/write indices and fill count for a power-of-2 ring of LENGTH
// slots. The block owns no storage; the parent FIFO writes slot wptr when
// we_ok is high and reads slot rptr while empty_n is high.
//
// With INIT_FULL=1 the ring comes out of reset holding every slot (0..LENGTH-1).
// This lets it act as a free-slot allocator that hands out slots 0, 1, 2, ...
// With INIT_FULL=0 it comes out of reset empty and behaves as a plain FIFO
// controller.
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rstn     in   asynchronous active-low reset
//   we       in   push request
//   re       in   pop request
//   full_n   out  1 = at least one free slot (length != LENGTH)
//   empty_n  out  1 = at least one entry (length != 0)
//   we_ok    out  accepted push (we & full_n), combinational
//   wptr     out  next slot to be written
//   rptr     out  slot holding the oldest entry (valid while empty_n=1)
//   length   out  current entry count, 0..LENGTH
// ---------------------------------------------------------------------------
module xcc #(
    parameter int LENGTH    = 16,
    parameter bit INIT_FULL = 1'b0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      we,
    input  logic                      re,
    output logic                      full_n,
    output logic                      empty_n,
    output logic                      we_ok,
    output logic [$clog2(LENGTH)-1:0] wptr,
    output logic [$clog2(LENGTH):0]   length
    ,
    output logic [$clog2(LENGTH)-1:0] rptr
);

    localparam int             AW      = $clog2(LENGTH);
    localparam logic [AW:0]    LEN_MAX = (AW+1)'(LENGTH);
    localparam logic [AW:0]    LEN_RST = INIT_FULL ? LEN_MAX : '0;

    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [AW:0]   length_reg;
    logic          re_ok;

    // Flags are decoded straight from the count, so they always agree with
    // length in the same cycle.
    assign full_n  = (length_reg != LEN_MAX);
    assign empty_n = (length_reg != '0);

    // A refused request never touches state, even when the other side of
    // the ring is active in the same cycle.
    assign we_ok = we & full_n;
    assign re_ok = re & empty_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_reg   <= '0;
            rptr_reg   <= '0;
            length_reg <= LEN_RST;
        end else begin
            // Pointers wrap by natural overflow of the AW-bit registers.
            if (we_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (re_ok) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            // Simultaneous accepted push and pop leave the count unchanged.
            if (we_ok && !re_ok) begin
                length_reg <= length_reg + 1'b1;
            end else if (re_ok && !we_ok) begin
                length_reg <= length_reg - 1'b1;
            end
        end
    end

    assign wptr   = wptr_reg;
    assign rptr   = rptr_reg;
    assign length = length_reg;

endmodule

// File: tb/tb_xcc.sv
module tb_xcc;

    logic       clk;
    logic       rstn;

    // Instance f: INIT_FULL=1, instance e: INIT_FULL=0
    logic       we_f, re_f, full_n_f, empty_n_f, we_ok_f;
    logic [3:0] wptr_f, rptr_f;
    logic [4:0] length_f;
    logic       we_e, re_e, full_n_e, empty_n_e, we_ok_e;
    logic [3:0] wptr_e, rptr_e;
    logic [4:0] length_e;

    int total;
    int bad;

    xcc #(.LENGTH(16), .INIT_FULL(1'b1)) u_f (
        .clk(clk), .rstn(rstn), .we(we_f), .re(re_f),
        .full_n(full_n_f), .empty_n(empty_n_f), .we_ok(we_ok_f),
        .wptr(wptr_f), .length(length_f), .rptr(rptr_f)
    );

    xcc #(.LENGTH(16), .INIT_FULL(1'b0)) u_e (
        .clk(clk), .rstn(rstn), .we(we_e), .re(re_e),
        .full_n(full_n_e), .empty_n(empty_n_e), .we_ok(we_ok_e),
        .wptr(wptr_e), .length(length_e), .rptr(rptr_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state, index 0 = instance f, 1 = instance e
    int m_len [2];
    int m_wp  [2];
    int m_rp  [2];

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        we_f  = 1'b0; re_f = 1'b0;
        we_e  = 1'b0; re_e = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;

        // Reset state
        chk("rst_f_len",   32'(length_f),  32'd16);
        chk("rst_f_fulln", 32'(full_n_f),  32'd0);
        chk("rst_f_empn",  32'(empty_n_f), 32'd1);
        chk("rst_f_rptr",  32'(rptr_f),    32'd0);
        chk("rst_f_wptr",  32'(wptr_f),    32'd0);
        chk("rst_e_len",   32'(length_e),  32'd0);
        chk("rst_e_fulln", 32'(full_n_e),  32'd1);
        chk("rst_e_empn",  32'(empty_n_e), 32'd0);
        step();

        // Push into a full ring is refused
        we_f = 1'b1;
        #1;
        chk("full_push_weok", 32'(we_ok_f), 32'd0);
        step();
        chk("full_push_len",  32'(length_f), 32'd16);
        chk("full_push_wptr", 32'(wptr_f),   32'd0);
        we_f = 1'b0;

        // Three pops from the initially full ring
        re_f = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("pop%0d_rptr", i), 32'(rptr_f),   32'(i));
            chk($sformatf("pop%0d_len", i),  32'(length_f), 32'(16 - i));
        end
        chk("pop3_fulln", 32'(full_n_f), 32'd1);
        re_f = 1'b0;
        we_f = 1'b1;
        #1;
        chk("push1_weok", 32'(we_ok_f), 32'd1);
        step();
        chk("push1_wptr", 32'(wptr_f),   32'd1);
        chk("push1_len",  32'(length_f), 32'd14);
        we_f = 1'b0;

        // Fill the empty ring with 16 pushes
        we_e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("fill%0d_weok", i), 32'(we_ok_e), 32'd1);
            step();
        end
        chk("fill_len",   32'(length_e),  32'd16);
        chk("fill_fulln", 32'(full_n_e),  32'd0);
        chk("fill_wptr",  32'(wptr_e),    32'd0);
        chk("fill_empn",  32'(empty_n_e), 32'd1);
        #1;
        chk("push17_weok", 32'(we_ok_e), 32'd0);
        step();
        chk("push17_len", 32'(length_e), 32'd16);
        we_e = 1'b0;

        // Drain to length 5, then 21 simultaneous push/pop cycles
        re_e = 1'b1;
        repeat (11) step();
        chk("drain_len",  32'(length_e), 32'd5);
        chk("drain_rptr", 32'(rptr_e),   32'd11);
        we_e = 1'b1;
        step();
        chk("rw_wptr", 32'(wptr_e),   32'd1);
        chk("rw_rptr", 32'(rptr_e),   32'd12);
        chk("rw_len",  32'(length_e), 32'd5);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("rw%0d_len", i),   32'(length_e),  32'd5);
            chk($sformatf("rw%0d_fulln", i), 32'(full_n_e),  32'd1);
            chk($sformatf("rw%0d_empn", i),  32'(empty_n_e), 32'd1);
        end
        chk("rw_end_wptr", 32'(wptr_e), 32'd5);
        chk("rw_end_rptr", 32'(rptr_e), 32'd0);

        // Drain to empty, then push+pop on an empty ring
        we_e = 1'b0;
        repeat (5) step();
        chk("empty_len",  32'(length_e),  32'd0);
        chk("empty_empn", 32'(empty_n_e), 32'd0);
        we_e = 1'b1;
        step();
        chk("epr_len",  32'(length_e),  32'd1);
        chk("epr_rptr", 32'(rptr_e),    32'd5);
        chk("epr_wptr", 32'(wptr_e),    32'd6);
        chk("epr_empn", 32'(empty_n_e), 32'd1);
        re_e = 1'b0;
        step();
        chk("ep2_len", 32'(length_e), 32'd2);

        // Asynchronous reset between clock edges
        re_f = 1'b1;
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_e_len",  32'(length_e), 32'd0);
        chk("arst_e_wptr", 32'(wptr_e),   32'd0);
        chk("arst_e_rptr", 32'(rptr_e),   32'd0);
        chk("arst_f_len",  32'(length_f), 32'd16);
        chk("arst_f_rptr", 32'(rptr_f),   32'd0);
        chk("arst_f_wptr", 32'(wptr_f),   32'd0);
        we_e = 1'b0;
        re_f = 1'b0;
        #1;
        rstn = 1'b1;
        step();

        // Random traffic against a reference counter model
        m_len[0] = 16; m_wp[0] = 0; m_rp[0] = 0;
        m_len[1] = 0;  m_wp[1] = 0; m_rp[1] = 0;
        for (int i = 0; i < 10000; i++) begin
            logic [3:0] r;
            int ok_w [2];
            int ok_r [2];
            r    = 4'($urandom);
            we_f = r[0]; re_f = r[1];
            we_e = r[2]; re_e = r[3];
            ok_w[0] = (we_f && m_len[0] != 16) ? 1 : 0;
            ok_r[0] = (re_f && m_len[0] != 0)  ? 1 : 0;
            ok_w[1] = (we_e && m_len[1] != 16) ? 1 : 0;
            ok_r[1] = (re_e && m_len[1] != 0)  ? 1 : 0;
            #1;
            chk("rnd_f_weok", 32'(we_ok_f), 32'(ok_w[0]));
            chk("rnd_e_weok", 32'(we_ok_e), 32'(ok_w[1]));
            step();
            for (int k = 0; k < 2; k++) begin
                m_wp[k]  = (m_wp[k] + ok_w[k]) % 16;
                m_rp[k]  = (m_rp[k] + ok_r[k]) % 16;
                m_len[k] = m_len[k] + ok_w[k] - ok_r[k];
            end
            chk("rnd_f_len",   32'(length_f),  32'(m_len[0]));
            chk("rnd_f_wptr",  32'(wptr_f),    32'(m_wp[0]));
            chk("rnd_f_rptr",  32'(rptr_f),    32'(m_rp[0]));
            chk("rnd_f_fulln", 32'(full_n_f),  32'(m_len[0] != 16));
            chk("rnd_f_empn",  32'(empty_n_f), 32'(m_len[0] != 0));
            chk("rnd_f_inv",   32'(4'(wptr_f - rptr_f)), 32'(length_f[3:0]));
            chk("rnd_f_range", 32'(length_f <= 5'd16), 32'd1);
            chk("rnd_e_len",   32'(length_e),  32'(m_len[1]));
            chk("rnd_e_wptr",  32'(wptr_e),    32'(m_wp[1]));
            chk("rnd_e_rptr",  32'(rptr_e),    32'(m_rp[1]));
            chk("rnd_e_fulln", 32'(full_n_e),  32'(m_len[1] != 16));
            chk("rnd_e_empn",  32'(empty_n_e), 32'(m_len[1] != 0));
            chk("rnd_e_inv",   32'(4'(wptr_e - rptr_e)), 32'(length_e[3:0]));
            chk("rnd_e_range", 32'(length_e <= 5'd16), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
